// File: rtl/fx3_slave_fifo_model.sv
// ---------------------------------------------------------------------------
// fx3_slave_fifo_model
//
// Behavioural-but-synthesizable stand-in for the FX3 end of a 32-bit GPIF II
// synchronous slave-FIFO link. The FPGA master writes into one socket, which
// drains to a host-side stream. It reads from a second socket, which a
// host-side stream fills.
//
// Ports
//   clk, reset_b        interface clock, asynchronous active-low reset
//   faddr               socket select (WR_ADDR = write socket, RD_ADDR = read)
//   fdata               bidirectional data bus, driven only for reads
//   slcs_b              chip select, active low
//   slwr_b, slrd_b      write / read strobes, active low
//   sloe_b              output enable, active low
//   pktend_b            packet end, active low
//   flaga_b..flagd_b    full / almost-full (write), empty / almost-empty (read)
//   host_wr_*           valid/ready push stream into the read socket
//   host_rd_*           first-word-fall-through pop stream from the write socket
//   zlp_count           saturating count of zero-length packets
//   err_*               sticky error indicators, cleared only by reset
// ---------------------------------------------------------------------------
module fx3_slave_fifo_model #(
  parameter int         DEPTH     = 16,
  parameter int         WATERMARK = 4,
  parameter int         RD_LAT    = 2,
  parameter int         FLAG_LAT  = 3,
  parameter logic [1:0] WR_ADDR   = 2'b00,
  parameter logic [1:0] RD_ADDR   = 2'b11
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [1:0]  faddr,
  inout  wire  [31:0] fdata,
  input  logic        slcs_b,
  input  logic        slwr_b,
  input  logic        slrd_b,
  input  logic        sloe_b,
  input  logic        pktend_b,
  output logic        flaga_b,
  output logic        flagb_b,
  output logic        flagc_b,
  output logic        flagd_b,
  input  logic [31:0] host_wr_data,
  input  logic        host_wr_valid,
  output logic        host_wr_ready,
  output logic [31:0] host_rd_data,
  output logic        host_rd_last,
  output logic        host_rd_valid,
  input  logic        host_rd_ready,
  output logic [7:0]  zlp_count,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_protocol
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_CNT = CW'(DEPTH - WATERMARK);
  localparam logic [CW-1:0] LOW_CNT  = CW'(WATERMARK);
  // Flag order {a, b, c, d}: write side idle-high, read side idle-low.
  localparam logic [3:0]    FLAG_RST = 4'b1100;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Strobe qualification; both strobes low at once cancels the access.
  logic cs, both_strb, fpga_wr, fpga_rd, fpga_zlp;

  assign cs        = ~slcs_b;
  assign both_strb = cs & ~slwr_b & ~slrd_b;
  assign fpga_wr   = cs & ~slwr_b &  slrd_b & (faddr == WR_ADDR);
  assign fpga_rd   = cs & ~slrd_b &  slwr_b & (faddr == RD_ADDR);
  assign fpga_zlp  = cs & ~pktend_b & slwr_b & slrd_b & (faddr == WR_ADDR);

  // ---------------- write socket (FPGA -> host) ----------------
  logic [32:0]   wr_mem [DEPTH];
  logic [AW-1:0] wr_wptr, wr_rptr;
  logic [CW-1:0] wr_count;
  logic          host_pop, wr_push, wr_drop;

  assign host_rd_valid = (wr_count != '0);
  assign host_pop      = host_rd_valid & host_rd_ready;
  // A full buffer still accepts when the host frees the head slot this cycle.
  assign wr_push       = fpga_wr & ((wr_count != FULL_CNT) | host_pop);
  assign wr_drop       = fpga_wr & ~wr_push;
  assign {host_rd_last, host_rd_data} = wr_mem[wr_rptr];

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wptr] <= {~pktend_b, fdata};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_wptr  <= '0;
      wr_rptr  <= '0;
      wr_count <= '0;
    end else begin
      if (wr_push)  wr_wptr <= wr_wptr + 1'b1;
      if (host_pop) wr_rptr <= wr_rptr + 1'b1;
      case ({wr_push, host_pop})
        2'b10:   wr_count <= wr_count + 1'b1;
        2'b01:   wr_count <= wr_count - 1'b1;
        default: wr_count <= wr_count;
      endcase
    end
  end

  // ---------------- read socket (host -> FPGA) ----------------
  logic [31:0]   rd_mem [DEPTH];
  logic [AW-1:0] rd_wptr, rd_rptr;
  logic [CW-1:0] rd_count;
  logic          rd_push, rd_pop, rd_under;

  assign host_wr_ready = (rd_count != FULL_CNT);
  assign rd_push       = host_wr_valid & host_wr_ready;
  // No bypass: a word pushed this cycle is not readable until the next one.
  assign rd_pop        = fpga_rd & (rd_count != '0);
  assign rd_under      = fpga_rd & (rd_count == '0);

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wptr] <= host_wr_data;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
    end else begin
      if (rd_push) rd_wptr <= rd_wptr + 1'b1;
      if (rd_pop)  rd_rptr <= rd_rptr + 1'b1;
      case ({rd_push, rd_pop})
        2'b10:   rd_count <= rd_count + 1'b1;
        2'b01:   rd_count <= rd_count - 1'b1;
        default: rd_count <= rd_count;
      endcase
    end
  end

  // ---------------- read data pipeline ----------------
  // Stage p0 captures the popped word; after RD_LAT edges it lands in
  // fdata_q. Underflow sends a bubble, so fdata_q keeps its previous word.
  logic [31:0] rd_data_p [RD_LAT];
  logic        rd_vld_p  [RD_LAT];
  logic [31:0] fdata_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_data_p[i] <= '0;
        rd_vld_p[i]  <= 1'b0;
      end
      fdata_q <= '0;
    end else begin
      rd_data_p[0] <= rd_mem[rd_rptr];
      rd_vld_p[0]  <= rd_pop;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_data_p[i] <= rd_data_p[i-1];
        rd_vld_p[i]  <= rd_vld_p[i-1];
      end
      if (rd_vld_p[RD_LAT-1]) fdata_q <= rd_data_p[RD_LAT-1];
    end
  end

  // Bus turnaround is purely combinational on the control pins; a low
  // slwr_b always keeps the bus released.
  logic fdata_oe;
  assign fdata_oe = reset_b & ~slcs_b & ~sloe_b & slwr_b;
  assign fdata    = fdata_oe ? fdata_q : 'z;

  // ---------------- flags ----------------
  logic [3:0] flag_raw;
  logic [3:0] flag_sr [FLAG_LAT];

  assign flag_raw = {(wr_count != FULL_CNT), (wr_count < HIGH_CNT),
                     (rd_count != '0),       (rd_count > LOW_CNT)};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < FLAG_LAT; i++) flag_sr[i] <= FLAG_RST;
    end else begin
      flag_sr[0] <= flag_raw;
      for (int i = 1; i < FLAG_LAT; i++) flag_sr[i] <= flag_sr[i-1];
    end
  end

  assign {flaga_b, flagb_b, flagc_b, flagd_b} = flag_sr[FLAG_LAT-1];

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      zlp_count     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_protocol  <= 1'b0;
    end else begin
      if (fpga_zlp)  zlp_count     <= sat_inc8(zlp_count);
      if (wr_drop)   err_overflow  <= 1'b1;
      if (rd_under)  err_underflow <= 1'b1;
      if (both_strb) err_protocol  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
module tb_fx3_slave_fifo_model;

  localparam int         DEPTH    = 16;
  localparam int         WM       = 4;
  localparam int         RD_LAT   = 2;
  localparam int         FLAG_LAT = 3;
  localparam logic [1:0] WR_A     = 2'b00;
  localparam logic [1:0] RD_A     = 2'b11;
  localparam int         HN       = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_b;
  logic [1:0]  faddr;
  logic        slcs_b, slwr_b, slrd_b, sloe_b, pktend_b;
  logic [31:0] tb_fd;
  logic        tb_fd_en;
  wire  [31:0] fdata;
  logic        flaga_b, flagb_b, flagc_b, flagd_b;
  logic [31:0] host_wr_data;
  logic        host_wr_valid, host_wr_ready;
  logic [31:0] host_rd_data;
  logic        host_rd_last, host_rd_valid, host_rd_ready;
  logic [7:0]  zlp_count;
  logic        err_overflow, err_underflow, err_protocol;

  assign fdata = tb_fd_en ? tb_fd : 'z;

  fx3_slave_fifo_model #(
    .DEPTH(DEPTH), .WATERMARK(WM), .RD_LAT(RD_LAT), .FLAG_LAT(FLAG_LAT),
    .WR_ADDR(WR_A), .RD_ADDR(RD_A)
  ) dut (
    .clk(clk), .reset_b(reset_b), .faddr(faddr), .fdata(fdata),
    .slcs_b(slcs_b), .slwr_b(slwr_b), .slrd_b(slrd_b), .sloe_b(sloe_b),
    .pktend_b(pktend_b),
    .flaga_b(flaga_b), .flagb_b(flagb_b), .flagc_b(flagc_b), .flagd_b(flagd_b),
    .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid),
    .host_wr_ready(host_wr_ready),
    .host_rd_data(host_rd_data), .host_rd_last(host_rd_last),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .zlp_count(zlp_count), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_protocol(err_protocol)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic last; logic [31:0] d; } hw_t;
  typedef struct { int due; logic [31:0] d; } fd_t;

  int          m_wcnt;
  logic [31:0] m_rq[$];
  hw_t         exp_host_q[$];
  fd_t         exp_fd_q[$];
  logic [31:0] m_fd_last;
  int          m_zlp;
  logic        m_eo, m_eu, m_ep;
  logic [3:0]  hist [HN];
  int          cyc;
  bit          mon_en;
  int          errors, checks;

  function automatic int hidx(input int c);
    return ((c % HN) + HN) % HN;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_wcnt = 0;
    m_rq.delete();
    exp_host_q.delete();
    exp_fd_q.delete();
    m_fd_last = '0;
    m_zlp = 0;
    m_eo = 0; m_eu = 0; m_ep = 0;
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    bit  cs, wr, rd, zl, pr, hpop, hpush;
    fd_t t;
    if (!reset_b) begin
      model_clear();
      hist[hidx(cyc)] = 4'b1100;
      return;
    end
    cs    = !slcs_b;
    pr    = cs && !slwr_b && !slrd_b;
    wr    = cs && !slwr_b && slrd_b && faddr == WR_A;
    rd    = cs && !slrd_b && slwr_b && faddr == RD_A;
    zl    = cs && !pktend_b && slwr_b && slrd_b && faddr == WR_A;
    hpop  = host_rd_ready && m_wcnt > 0;
    hpush = host_wr_valid && m_rq.size() < DEPTH;
    if (pr) m_ep = 1;
    if (hpop) m_wcnt--;
    if (wr) begin
      if (m_wcnt < DEPTH) begin
        m_wcnt++;
        exp_host_q.push_back({!pktend_b, tb_fd});
      end else m_eo = 1;
    end
    if (zl && m_zlp < 255) m_zlp++;
    if (rd) begin
      if (m_rq.size() > 0) begin
        t.due = cyc + RD_LAT;
        t.d   = m_rq.pop_front();
        exp_fd_q.push_back(t);
      end else m_eu = 1;
    end
    if (hpush) m_rq.push_back(host_wr_data);
    hist[hidx(cyc)] = {m_wcnt != DEPTH, m_wcnt < DEPTH - WM,
                       m_rq.size() != 0, m_rq.size() > WM};
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    slcs_b = 0; slwr_b = 1; slrd_b = 1; sloe_b = 0; pktend_b = 1;
    faddr = WR_A; tb_fd_en = 0; host_wr_valid = 0;
  endtask

  task automatic async_reset(input logic [31:0] pat);
    #2;
    reset_b  = 0;
    slwr_b   = 1;
    sloe_b   = 0;
    slcs_b   = 0;
    tb_fd    = pat;
    tb_fd_en = 1;
    model_clear();
    for (int k = 0; k <= FLAG_LAT; k++) hist[hidx(cyc - k)] = 4'b1100;
    #1;
    chk("fdata_released_in_reset", fdata, pat);
    chk("flags_in_reset", {flaga_b, flagb_b, flagc_b, flagd_b}, 4'b1100);
    chk("host_if_in_reset", {host_wr_ready, host_rd_valid}, 2'b10);
    chk("status_in_reset", {zlp_count, err_overflow, err_underflow, err_protocol}, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0] ef;
    hw_t        h;
    fd_t        t;
    bit         drv;
    if (mon_en && reset_b) begin
      ef = hist[hidx(cyc - FLAG_LAT)];
      chk("flags", {flaga_b, flagb_b, flagc_b, flagd_b}, ef);
      chk("host_rd_valid", host_rd_valid, m_wcnt > 0);
      chk("host_wr_ready", host_wr_ready, m_rq.size() < DEPTH);
      chk("zlp_count", zlp_count, m_zlp);
      chk("err_bits", {err_overflow, err_underflow, err_protocol}, {m_eo, m_eu, m_ep});
      if (host_rd_valid && host_rd_ready) begin
        if (exp_host_q.size() == 0) chk("host_rd_unexpected", 1'b1, 1'b0);
        else begin
          h = exp_host_q.pop_front();
          chk("host_rd_word", {host_rd_last, host_rd_data}, h);
        end
      end
      drv = !slcs_b && !sloe_b && slwr_b;
      if (exp_fd_q.size() > 0 && exp_fd_q[0].due == cyc) begin
        t = exp_fd_q.pop_front();
        m_fd_last = t.d;
        if (drv) chk("fdata_read", fdata, m_fd_last);
      end else if (drv) begin
        chk("fdata_hold", fdata, m_fd_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  int op;

  initial begin
    errors = 0; checks = 0; cyc = 0; mon_en = 0;
    for (int i = 0; i < HN; i++) hist[i] = 4'b1100;
    model_clear();
    idle_in();
    host_rd_ready = 0;
    host_wr_data  = '0;
    reset_b  = 0;
    tb_fd    = 32'h5A5A_C3C3;
    tb_fd_en = 1;
    tick(); tick();
    chk("rst_fdata_released", fdata, 32'h5A5A_C3C3);
    chk("rst_flags", {flaga_b, flagb_b, flagc_b, flagd_b}, 4'b1100);
    chk("rst_zlp", zlp_count, 8'd0);
    chk("rst_host_if", {host_wr_ready, host_rd_valid}, 2'b10);
    tb_fd_en = 0;
    reset_b  = 1;
    mon_en   = 1;

    // Fill the write socket to full, then one more write overflows.
    for (int i = 0; i < 17; i++) begin
      idle_in();
      slwr_b = 0; faddr = WR_A; tb_fd_en = 1; tb_fd = 32'(i + 1);
      pktend_b = (i == 15) ? 1'b0 : 1'b1;
      tick();
    end
    idle_in();
    for (int i = 0; i < 5; i++) tick();
    chk("overflow_sticky", err_overflow, 1'b1);
    host_rd_ready = 1;
    for (int i = 0; i < 20; i++) tick();
    host_rd_ready = 0;
    chk("drain_complete", exp_host_q.size(), 0);

    // Host fills the read socket, FPGA reads three words back.
    for (int i = 0; i < 3; i++) begin
      idle_in();
      host_wr_valid = 1; host_wr_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    idle_in();
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_in();
      slrd_b = 0; faddr = RD_A;
      tick();
    end
    idle_in();
    for (int i = 0; i < 8; i++) tick();
    chk("fdata_last_of_three", fdata, 32'hA5A5_0002);

    // Read on an empty socket.
    idle_in();
    slrd_b = 0; faddr = RD_A;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    chk("underflow_sticky", err_underflow, 1'b1);
    chk("underflow_hold", fdata, 32'hA5A5_0002);

    // Three zero-length packets.
    for (int i = 0; i < 3; i++) begin
      idle_in();
      pktend_b = 0; faddr = WR_A;
      tick();
    end
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    chk("zlp_three", zlp_count, 8'd3);
    chk("zlp_no_data", host_rd_valid, 1'b0);

    // Buffer five words on both sockets, start reading, reset mid-burst.
    for (int i = 0; i < 5; i++) begin
      idle_in();
      slwr_b = 0; faddr = WR_A; tb_fd_en = 1; tb_fd = 32'hBEEF_0000 + 32'(i);
      host_wr_valid = 1; host_wr_data = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      idle_in();
      slrd_b = 0; faddr = RD_A;
      tick();
    end
    async_reset(32'h1357_9BDF);
    tick(); tick();
    idle_in();
    reset_b = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_reset_errors", {err_overflow, err_underflow, err_protocol}, 3'b000);
    chk("post_reset_flags", {flaga_b, flagb_b, flagc_b, flagd_b}, 4'b1100);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      op            = $urandom_range(0, 9);
      slcs_b        = ($urandom_range(0, 9) == 0);
      sloe_b        = ($urandom_range(0, 7) == 0);
      host_rd_ready = $urandom_range(0, 1);
      host_wr_valid = $urandom_range(0, 1);
      host_wr_data  = $urandom;
      case (op)
        0, 1, 2: begin
          slwr_b   = 0;
          faddr    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : WR_A;
          pktend_b = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
          tb_fd_en = 1;
          tb_fd    = $urandom;
        end
        3, 4, 5: begin
          slrd_b = 0;
          faddr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : RD_A;
        end
        6: begin
          pktend_b = 0;
          faddr    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : WR_A;
        end
        7: begin
          if ($urandom_range(0, 15) == 0) begin
            slwr_b = 0; slrd_b = 0; tb_fd_en = 1; tb_fd = $urandom;
          end
        end
        default: ;
      endcase
      tick();
    end

    idle_in();
    host_rd_ready = 1;
    for (int i = 0; i < 40; i++) tick();
    chk("final_host_drain", exp_host_q.size(), 0);
    chk("final_fdata_pending", exp_fd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx3_slave_fifo_model.md
Name: fx3_slave_fifo_model

Overview:
Synthesizable model of the FX3 side of the 32-bit GPIF II synchronous slave-FIFO interface. It is the responder to the FPGA-side slave-FIFO master. It provides two sockets:
- a write socket that captures FPGA writes and drains them to a host-side stream;
- a read socket that a host-side stream fills and the FPGA reads.

It drives the four active-low flags with FX3-like latency. It is used in simulation and loopback hardware tests in place of a real FX3.

Parameters:
DEPTH, 16, words per socket buffer (power of 2, >= 4)
WATERMARK, 4, partial-flag threshold in words (1..DEPTH-1)
RD_LAT, 2, cycles from sampled read strobe to data on fdata (1..4)
FLAG_LAT, 3, cycles of delay on every flag (1..4)
WR_ADDR, 2'b00, faddr value selecting the write socket
RD_ADDR, 2'b11, faddr value selecting the read socket

Ports:
clk  in  1  interface clock; all logic on rising edge
reset_b  in  1  asynchronous active-low reset
faddr  in  2  socket select from FPGA
fdata  inout  32  bidirectional data bus
slcs_b  in  1  chip select, active low
slwr_b  in  1  write strobe, active low
slrd_b  in  1  read strobe, active low
sloe_b  in  1  output enable, active low
pktend_b  in  1  packet end, active low
flaga_b  out  1  low = write socket full
flagb_b  out  1  low = write socket count >= DEPTH-WATERMARK
flagc_b  out  1  low = read socket empty
flagd_b  out  1  low = read socket count <= WATERMARK
host_wr_data  in  32  word for read socket
host_wr_valid  in  1  host push request
host_wr_ready  out  1  read socket not full
host_rd_data  out  32  head word of write socket
host_rd_last  out  1  head word carried pktend
host_rd_valid  out  1  write socket not empty
host_rd_ready  in  1  host pop
zlp_count  out  8  zero-length packets received, saturating
err_overflow  out  1  sticky: write dropped on full
err_underflow  out  1  sticky: read on empty
err_protocol  out  1  sticky: slwr_b and slrd_b low together

Behaviour:
- Reset (async, reset_b=0):
  - Pointers, counts, pipelines, zlp_count and error bits clear.
  - fdata goes to z immediately.
  - Flags: flaga_b=1, flagb_b=1, flagc_b=0, flagd_b=0.
  - host_wr_ready=1, host_rd_valid=0.
- Access sampling: an access is qualified only when slcs_b=0 at the rising edge. Strobes with faddr not equal to the target socket address are ignored.
- FPGA write (slwr_b=0, slrd_b=1, faddr=WR_ADDR):
  - Push {last=~pktend_b, fdata} into the write buffer.
  - Accepted if count<DEPTH, or if a host pop occurs in the same cycle.
  - Otherwise the word is dropped and err_overflow is set.
- Zero-length packet (pktend_b=0, slwr_b=1, slrd_b=1, faddr=WR_ADDR): zlp_count+1, saturating at 255. Nothing is pushed.
- FPGA read (slrd_b=0, slwr_b=1, faddr=RD_ADDR):
  - If the read buffer is non-empty, pop at that edge. The word enters an RD_LAT-stage pipeline and appears at the pipeline output RD_LAT edges later.
  - If empty: no pop, err_underflow is set, and the pipeline shifts in its previous output (data holds).
  - There is no same-cycle bypass from host push to an empty buffer.
- fdata driver: drives the pipeline output when slcs_b=0 and sloe_b=0 (combinational on these inputs). Otherwise z. Never drives during a qualified write.
- slwr_b=0 and slrd_b=0 together: both strobes are ignored and err_protocol is set.
- Host side:
  - host_rd_* is first-word-fall-through; pop on host_rd_valid & host_rd_ready.
  - Push into the read buffer on host_wr_valid & host_wr_ready.
  - Simultaneous push and pop on one buffer leaves the count unchanged.
- Flags:
  - Raw conditions are computed from the registered counts after each edge.
  - Each flag passes through a FLAG_LAT-deep shift register.
  - Example: a write that fills the buffer at edge N drives flaga_b low after edge N+FLAG_LAT.
  - The FPGA master must tolerate writes inside the latency window; overflow handling above applies.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits wide.
- Error bits clear only on reset.

Test Plan:
- Reset with reset_b=0 for 2 cycles → fdata=z, flaga_b=1, flagb_b=1, flagc_b=0, flagd_b=0, zlp_count=0.
- FPGA writes 0x00000001..0x00000010 (16 words), pktend_b=0 on the last; host_rd_ready=0 → flagb_b low 3 cycles after the 12th write, flaga_b low 3 cycles after the 16th. A 17th write sets err_overflow. Host then drains 16 words in order, last=1 only on 0x00000010.
- Host pushes 0xA5A50000..0xA5A50002; FPGA asserts slrd_b for 3 cycles with sloe_b=0 → fdata shows the three words starting 2 edges after the first strobe edge. flagc_b returns low 3 cycles after the final pop.
- slrd_b on empty read socket → err_underflow=1, fdata holds the previous value, no pointer movement.
- pktend_b=0 with slwr_b=1 on WR_ADDR, three times → zlp_count=3, host_rd_valid stays 0.
- reset_b asserted mid-burst with 5 words buffered → fdata=z immediately; after release both sockets are empty and all errors=0.
